// File: rtl/ibex_pkg.sv
// Shared types for the register-file write-port arbiter.
// Writeback source select plus register-file geometry.
package ibex_pkg;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_LSU,
    WB_SRC_ID,
    WB_SRC_COP
  } wb_src_e;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned RegDataW = 32;
  localparam int unsigned NumRegs  = 32;

endpackage

// File: rtl/ibex_rf_scoreboard.sv
// COP destination scoreboard: pending bitmap plus in-flight credit counter.
// Set beats clear on the same bit; x0 is never marked pending.
module ibex_rf_scoreboard
  import ibex_pkg::*;
#(
  parameter int unsigned MaxCopOutstanding = 4,
  localparam int unsigned CntW = $clog2(MaxCopOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                set_i,
  input  logic [RegAddrW-1:0] set_addr_i,
  input  logic                clr_i,
  input  logic [RegAddrW-1:0] clr_addr_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [NumRegs-1:0]  pending_o,
  output logic [CntW-1:0]     count_o,
  output logic                full_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(MaxCopOutstanding);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [NumRegs-1:0] pending_q, pending_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_addr_i] = 1'b0;
    if (set_i) pending_d[set_addr_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  // Saturating: never wraps past Max or below zero
  always_comb begin
    cnt_d = cnt_q;
    unique case ({inc_i, dec_i})
      2'b10: if (cnt_q < CntMax) cnt_d = cnt_q + CntOne;
      2'b01: if (cnt_q != '0) cnt_d = cnt_q - CntOne;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_o = pending_q;
  assign count_o   = cnt_q;
  assign full_o    = (cnt_q >= CntMax);

endmodule

// File: rtl/ibex_rf_wport_arbiter.sv
// Register-file write-port arbiter for LSU, ID/EX and decoupled COP results.
// LSU always wins; ID and COP alternate via rr_q when both request.
module ibex_rf_wport_arbiter
  import ibex_pkg::*;
#(
  parameter bit          ResetAll          = 1'b0,
  parameter bit          RegOutput         = 1'b0,
  parameter int unsigned MaxCopOutstanding = 4,
  localparam int unsigned CntW = $clog2(MaxCopOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                lsu_we_i,
  input  logic [RegAddrW-1:0] lsu_waddr_i,
  input  logic [RegDataW-1:0] lsu_wdata_i,
  input  logic                id_we_i,
  input  logic [RegAddrW-1:0] id_waddr_i,
  input  logic [RegDataW-1:0] id_wdata_i,
  output logic                id_ready_o,
  input  logic                cop_issue_i,
  input  logic [RegAddrW-1:0] cop_issue_waddr_i,
  output logic                cop_issue_ready_o,
  input  logic                cop_valid_i,
  input  logic [RegAddrW-1:0] cop_waddr_i,
  input  logic [RegDataW-1:0] cop_wdata_i,
  output logic                cop_ready_o,
  output logic                rf_we_o,
  output logic [RegAddrW-1:0] rf_waddr_o,
  output logic [RegDataW-1:0] rf_wdata_o,
  output logic [NumRegs-1:0]  rf_pending_o,
  output logic [CntW-1:0]     cop_outstanding_o
);

  logic                rr_q, rr_d;
  logic                id_gnt, cop_gnt;
  wb_src_e             src;
  logic [RegAddrW-1:0] gnt_waddr;
  logic [RegDataW-1:0] gnt_wdata;
  logic                gnt_we;
  logic                issue_hs, sb_full;
  logic                clr;
  logic [RegAddrW-1:0] clr_addr;
  logic [NumRegs-1:0]  pending;

  assign id_ready_o  = !lsu_we_i && (!cop_valid_i || !rr_q);
  assign cop_ready_o = !lsu_we_i && (!id_we_i || rr_q);
  assign id_gnt      = id_we_i && id_ready_o;
  assign cop_gnt     = cop_valid_i && cop_ready_o;

  always_comb begin
    src = WB_SRC_NONE;
    unique case (1'b1)
      lsu_we_i: src = WB_SRC_LSU;
      id_gnt:   src = WB_SRC_ID;
      cop_gnt:  src = WB_SRC_COP;
      default:  ;
    endcase
  end

  always_comb begin
    gnt_waddr = '0;
    gnt_wdata = '0;
    unique case (src)
      WB_SRC_LSU: begin
        gnt_waddr = lsu_waddr_i;
        gnt_wdata = lsu_wdata_i;
      end
      WB_SRC_ID: begin
        gnt_waddr = id_waddr_i;
        gnt_wdata = id_wdata_i;
      end
      WB_SRC_COP: begin
        gnt_waddr = cop_waddr_i;
        gnt_wdata = cop_wdata_i;
      end
      default: ;
    endcase
  end

  // x0 writes are consumed but never reach the RF
  assign gnt_we = (src != WB_SRC_NONE) && (gnt_waddr != '0);

  assign rr_d = (id_gnt || cop_gnt) ? id_gnt : rr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_q <= 1'b0;
    else         rr_q <= rr_d;
  end

  if (RegOutput) begin : g_regout
    logic                we_q, cop_clr_q;
    logic [RegAddrW-1:0] waddr_q;
    logic [RegDataW-1:0] wdata_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        we_q      <= 1'b0;
        cop_clr_q <= 1'b0;
      end else begin
        we_q      <= gnt_we;
        cop_clr_q <= (src == WB_SRC_COP);
      end
    end

    if (ResetAll) begin : g_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          waddr_q <= '0;
          wdata_q <= '0;
        end else begin
          waddr_q <= gnt_waddr;
          wdata_q <= gnt_wdata;
        end
      end
    end else begin : g_nrst
      always_ff @(posedge clk_i) begin
        waddr_q <= gnt_waddr;
        wdata_q <= gnt_wdata;
      end
    end

    // Pending clears together with the delayed RF write
    assign rf_we_o    = we_q;
    assign rf_waddr_o = waddr_q;
    assign rf_wdata_o = wdata_q;
    assign clr        = cop_clr_q;
    assign clr_addr   = waddr_q;
  end else begin : g_comb
    assign rf_we_o    = gnt_we;
    assign rf_waddr_o = gnt_waddr;
    assign rf_wdata_o = gnt_wdata;
    assign clr        = cop_gnt;
    assign clr_addr   = cop_waddr_i;
  end

  assign issue_hs = cop_issue_i && cop_issue_ready_o;

  assign cop_issue_ready_o = !sb_full &&
    ((cop_issue_waddr_i == '0) || !pending[cop_issue_waddr_i]);

  ibex_rf_scoreboard #(
    .MaxCopOutstanding(MaxCopOutstanding)
  ) u_scoreboard (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .set_i     (issue_hs),
    .set_addr_i(cop_issue_waddr_i),
    .clr_i     (clr),
    .clr_addr_i(clr_addr),
    .inc_i     (issue_hs),
    .dec_i     (cop_gnt),
    .pending_o (pending),
    .count_o   (cop_outstanding_o),
    .full_o    (sb_full)
  );

  assign rf_pending_o = pending;

  a_cop_credit : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cop_gnt |-> (cop_outstanding_o != '0));

  a_cop_pending : assert property (@(posedge clk_i) disable iff (!rst_ni)
    cop_gnt |-> ((cop_waddr_i == '0) || pending[cop_waddr_i]));

  a_id_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (id_we_i && !id_ready_o) |=>
    (id_we_i && $stable(id_waddr_i) && $stable(id_wdata_i)));

  a_cop_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (cop_valid_i && !cop_ready_o) |=>
    (cop_valid_i && $stable(cop_waddr_i) && $stable(cop_wdata_i)));

  a_no_x0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    rf_we_o |-> (rf_waddr_o != '0));

endmodule

// File: tb/tb_ibex_rf_wport_arbiter.sv
// Bench for ibex_rf_wport_arbiter: directed scenarios plus random traffic.
// Random traffic is checked against an in-flight-queue model of the COP.
module tb_ibex_rf_wport_arbiter;

  localparam int Max = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  int          n_chk = 0;
  int          n_fail = 0;

  logic        lsu_we, id_we, cop_issue, cop_valid;
  logic [4:0]  lsu_waddr, id_waddr, cop_issue_waddr, cop_waddr;
  logic [31:0] lsu_wdata, id_wdata, cop_wdata;
  logic        id_ready, cop_issue_ready, cop_ready, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, rf_pending;
  logic [2:0]  cop_out;

  logic        b_lsu_we, b_id_we, b_cop_issue, b_cop_valid;
  logic [4:0]  b_lsu_waddr, b_id_waddr, b_cop_issue_waddr, b_cop_waddr;
  logic [31:0] b_lsu_wdata, b_id_wdata, b_cop_wdata;
  logic        b_id_ready, b_cop_issue_ready, b_cop_ready, b_rf_we;
  logic [4:0]  b_rf_waddr;
  logic [31:0] b_rf_wdata, b_rf_pending;
  logic [2:0]  b_cop_out;

  always #5 clk = ~clk;

  ibex_rf_wport_arbiter #(
    .ResetAll(1'b0), .RegOutput(1'b0), .MaxCopOutstanding(Max)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_we_i(lsu_we), .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
    .id_we_i(id_we), .id_waddr_i(id_waddr), .id_wdata_i(id_wdata),
    .id_ready_o(id_ready),
    .cop_issue_i(cop_issue), .cop_issue_waddr_i(cop_issue_waddr),
    .cop_issue_ready_o(cop_issue_ready),
    .cop_valid_i(cop_valid), .cop_waddr_i(cop_waddr),
    .cop_wdata_i(cop_wdata), .cop_ready_o(cop_ready),
    .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
    .rf_pending_o(rf_pending), .cop_outstanding_o(cop_out)
  );

  ibex_rf_wport_arbiter #(
    .ResetAll(1'b1), .RegOutput(1'b1), .MaxCopOutstanding(Max)
  ) dut_reg (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_we_i(b_lsu_we), .lsu_waddr_i(b_lsu_waddr),
    .lsu_wdata_i(b_lsu_wdata),
    .id_we_i(b_id_we), .id_waddr_i(b_id_waddr), .id_wdata_i(b_id_wdata),
    .id_ready_o(b_id_ready),
    .cop_issue_i(b_cop_issue), .cop_issue_waddr_i(b_cop_issue_waddr),
    .cop_issue_ready_o(b_cop_issue_ready),
    .cop_valid_i(b_cop_valid), .cop_waddr_i(b_cop_waddr),
    .cop_wdata_i(b_cop_wdata), .cop_ready_o(b_cop_ready),
    .rf_we_o(b_rf_we), .rf_waddr_o(b_rf_waddr), .rf_wdata_o(b_rf_wdata),
    .rf_pending_o(b_rf_pending), .cop_outstanding_o(b_cop_out)
  );

  task automatic zero_inputs();
    lsu_we = 0; lsu_waddr = 0; lsu_wdata = 0;
    id_we = 0; id_waddr = 0; id_wdata = 0;
    cop_issue = 0; cop_issue_waddr = 0;
    cop_valid = 0; cop_waddr = 0; cop_wdata = 0;
    b_lsu_we = 0; b_lsu_waddr = 0; b_lsu_wdata = 0;
    b_id_we = 0; b_id_waddr = 0; b_id_wdata = 0;
    b_cop_issue = 0; b_cop_issue_waddr = 0;
    b_cop_valid = 0; b_cop_waddr = 0; b_cop_wdata = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++; if (rf_we !== 1'b0) begin n_fail++;
      $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
    n_chk++; if (rf_pending !== 32'h0) begin n_fail++;
      $display("FAIL reset_pending: got %h want 0", rf_pending); end
    n_chk++; if (cop_out !== 3'd0) begin n_fail++;
      $display("FAIL reset_count: got %0d want 0", cop_out); end
    n_chk++; if (id_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_id_ready: got %0b want 1", id_ready); end
    n_chk++; if (cop_issue_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_issue_ready: got %0b want 1", cop_issue_ready); end
    n_chk++; if ({b_rf_we, b_rf_waddr, b_rf_wdata} !== 38'h0) begin n_fail++;
      $display("FAIL reset_regout_rf: got %0b/%0d/%h want 0",
               b_rf_we, b_rf_waddr, b_rf_wdata); end
  endtask

  task automatic test_lsu_priority();
    @(negedge clk);
    cop_issue = 1; cop_issue_waddr = 7;
    @(negedge clk);
    cop_issue = 0;
    lsu_we = 1; lsu_waddr = 5; lsu_wdata = 32'h55;
    id_we = 1; id_waddr = 6; id_wdata = 32'h66;
    cop_valid = 1; cop_waddr = 7; cop_wdata = 32'h77;
    #1;
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h55}) begin
      n_fail++; $display("FAIL lsu_wins: got %0b/%0d/%h want 1/5/55",
                         rf_we, rf_waddr, rf_wdata); end
    n_chk++; if ({id_ready, cop_ready} !== 2'b00) begin n_fail++;
      $display("FAIL lsu_stalls: got id=%0b cop=%0b want 0/0",
               id_ready, cop_ready); end
    @(negedge clk);
    lsu_we = 0;
    #1;
    n_chk++; if ({rf_waddr, cop_ready} !== {5'd6, 1'b0}) begin n_fail++;
      $display("FAIL lsu_rr_kept: got addr=%0d cop_rdy=%0b want 6/0",
               rf_waddr, cop_ready); end
    @(negedge clk);
    id_we = 0;
    #1;
    n_chk++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h77}) begin
      n_fail++; $display("FAIL lsu_cop_after: got %0b/%0d/%h want 1/7/77",
                         rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
    cop_valid = 0;
  endtask

  task automatic test_contention();
    logic [4:0] exp_a;
    @(negedge clk);
    cop_issue = 1; cop_issue_waddr = 4;
    @(negedge clk);
    cop_issue = 0;
    id_we = 1; id_waddr = 3; id_wdata = 32'h33;
    cop_valid = 1; cop_waddr = 4; cop_wdata = 32'h44;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      cop_issue = (i == 2);
      #1;
      exp_a = (i % 2 == 0) ? 5'd3 : 5'd4;
      n_chk++; if ({rf_we, rf_waddr} !== {1'b1, exp_a}) begin n_fail++;
        $display("FAIL contend_%0d: got %0b/%0d want 1/%0d",
                 i, rf_we, rf_waddr, exp_a); end
      n_chk++; if (id_ready !== (i % 2 == 0)) begin n_fail++;
        $display("FAIL contend_idrdy_%0d: got %0b", i, id_ready); end
    end
    @(negedge clk);
    cop_issue = 0; cop_valid = 0;
    #1;
    n_chk++; if (rf_waddr !== 5'd3) begin n_fail++;
      $display("FAIL contend_tail: got %0d want 3", rf_waddr); end
    @(negedge clk);
    id_we = 0;
  endtask

  task automatic test_issue_fill();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cop_issue = 1; cop_issue_waddr = 5'(k);
    end
    @(negedge clk);
    cop_issue = 1; cop_issue_waddr = 5;
    #1;
    n_chk++; if (cop_out !== 3'd4) begin n_fail++;
      $display("FAIL fill_count: got %0d want 4", cop_out); end
    n_chk++; if (cop_issue_ready !== 1'b0) begin n_fail++;
      $display("FAIL fill_ready: got %0b want 0", cop_issue_ready); end
    n_chk++; if (rf_pending !== 32'h1E) begin n_fail++;
      $display("FAIL fill_pending: got %h want 1e", rf_pending); end
    @(negedge clk);
    cop_issue = 0;
    cop_valid = 1; cop_waddr = 2; cop_wdata = 32'h22;
    #1;
    n_chk++; if (cop_out !== 3'd4) begin n_fail++;
      $display("FAIL fill_saturate: got %0d want 4", cop_out); end
    @(negedge clk);
    cop_valid = 0;
    #1;
    n_chk++; if ({rf_pending, cop_out} !== {32'h1A, 3'd3}) begin n_fail++;
      $display("FAIL fill_ret_x2: got %h/%0d want 1a/3",
               rf_pending, cop_out); end
  endtask

  task automatic test_waw_same_cycle();
    @(negedge clk);
    cop_valid = 1; cop_waddr = 3;
    @(negedge clk);
    cop_waddr = 4;
    @(negedge clk);
    cop_valid = 0;
    cop_issue = 1; cop_issue_waddr = 9;
    @(negedge clk);
    #1;
    n_chk++; if (cop_issue_ready !== 1'b0) begin n_fail++;
      $display("FAIL waw_block: got %0b want 0", cop_issue_ready); end
    @(negedge clk);
    cop_issue_waddr = 10;
    cop_valid = 1; cop_waddr = 1;
    #1;
    n_chk++; if ({cop_issue_ready, cop_ready} !== 2'b11) begin n_fail++;
      $display("FAIL same_cyc_rdy: got %0b/%0b want 1/1",
               cop_issue_ready, cop_ready); end
    @(negedge clk);
    cop_issue = 0; cop_valid = 0;
    #1;
    n_chk++; if ({rf_pending, cop_out} !== {32'h600, 3'd2}) begin n_fail++;
      $display("FAIL same_cyc: got %h/%0d want 600/2", rf_pending, cop_out); end
    @(negedge clk);
    cop_valid = 1; cop_waddr = 9;
    @(negedge clk);
    cop_waddr = 10;
    @(negedge clk);
    cop_valid = 0;
    #1;
    n_chk++; if (cop_out !== 3'd0) begin n_fail++;
      $display("FAIL drain_count: got %0d want 0", cop_out); end
  endtask

  task automatic test_random();
    logic [4:0]  inflight[$];
    logic [31:0] exp_pend;
    bit          prefer_cop, id_act, cop_act, iss, drain, exp_ir, exp_cr, exp_isr;
    logic [4:0]  id_a, cop_a, iss_a, exp_a;
    logic [31:0] id_d, cop_d, exp_d;
    int          cop_idx, win;
    do_reset();
    prefer_cop = 0; id_act = 0; cop_act = 0;
    id_a = 0; cop_a = 0; id_d = 0; cop_d = 0; cop_idx = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      exp_pend = 0;
      foreach (inflight[k]) if (inflight[k] != 0) exp_pend[inflight[k]] = 1'b1;
      n_chk++; if ({rf_pending, cop_out} !== {exp_pend, 3'(inflight.size())})
      begin n_fail++;
        $display("FAIL rnd_state c%0d: got %h/%0d want %h/%0d", cyc,
                 rf_pending, cop_out, exp_pend, inflight.size()); end
      drain = (cyc >= 360);
      lsu_we = !drain && ($urandom_range(0, 3) == 0);
      lsu_waddr = 5'($urandom_range(0, 31));
      lsu_wdata = $urandom;
      if (!id_act && !drain && $urandom_range(0, 1) == 1) begin
        id_act = 1; id_a = 5'($urandom_range(0, 31)); id_d = $urandom;
      end
      if (!cop_act && cyc < 390 && inflight.size() > 0 &&
          $urandom_range(0, 1) == 1) begin
        cop_act = 1;
        cop_idx = $urandom_range(0, inflight.size() - 1);
        cop_a = inflight[cop_idx]; cop_d = $urandom;
      end
      iss = !drain && ($urandom_range(0, 2) == 0);
      iss_a = 5'($urandom_range(0, 15));
      id_we = id_act; id_waddr = id_a; id_wdata = id_d;
      cop_valid = cop_act; cop_waddr = cop_a; cop_wdata = cop_d;
      cop_issue = iss; cop_issue_waddr = iss_a;
      #1;
      if (lsu_we) win = 1;
      else if (id_act && cop_act) win = prefer_cop ? 3 : 2;
      else if (id_act) win = 2;
      else if (cop_act) win = 3;
      else win = 0;
      exp_ir = !lsu_we && !(cop_act && prefer_cop);
      exp_cr = !lsu_we && !(id_act && !prefer_cop);
      exp_isr = (inflight.size() < Max) && (iss_a == 0 || !exp_pend[iss_a]);
      exp_a = (win == 1) ? lsu_waddr : (win == 2) ? id_a : cop_a;
      exp_d = (win == 1) ? lsu_wdata : (win == 2) ? id_d : cop_d;
      n_chk++;
      if ({id_ready, cop_ready, cop_issue_ready} !== {exp_ir, exp_cr, exp_isr})
      begin n_fail++;
        $display("FAIL rnd_ready c%0d: got %b%b%b want %b%b%b", cyc, id_ready,
                 cop_ready, cop_issue_ready, exp_ir, exp_cr, exp_isr); end
      n_chk++; if (rf_we !== (win != 0 && exp_a != 0)) begin n_fail++;
        $display("FAIL rnd_we c%0d: got %0b win=%0d addr=%0d", cyc, rf_we,
                 win, exp_a); end
      if (win != 0 && exp_a != 0) begin
        n_chk++; if ({rf_waddr, rf_wdata} !== {exp_a, exp_d}) begin n_fail++;
          $display("FAIL rnd_wr c%0d: got %0d/%h want %0d/%h", cyc, rf_waddr,
                   rf_wdata, exp_a, exp_d); end
      end
      if (win == 2) begin id_act = 0; prefer_cop = 1; end
      if (win == 3) begin
        cop_act = 0; prefer_cop = 0; inflight.delete(cop_idx);
      end
      if (iss && exp_isr) inflight.push_back(iss_a);
    end
    @(negedge clk);
    zero_inputs();
  endtask

  task automatic test_regout();
    @(negedge clk);
    b_id_we = 1; b_id_waddr = 8; b_id_wdata = 32'hDEADBEEF;
    #1;
    n_chk++; if ({b_id_ready, b_rf_we} !== 2'b10) begin n_fail++;
      $display("FAIL reg_same_cyc: got rdy=%0b we=%0b want 1/0",
               b_id_ready, b_rf_we); end
    @(negedge clk);
    b_id_waddr = 0; b_id_wdata = 32'h1234;
    #1;
    n_chk++; if ({b_rf_we, b_rf_waddr, b_rf_wdata} !== {1'b1, 5'd8, 32'hDEADBEEF})
    begin n_fail++; $display("FAIL reg_delayed: got %0b/%0d/%h want 1/8/deadbeef",
                             b_rf_we, b_rf_waddr, b_rf_wdata); end
    n_chk++; if (b_id_ready !== 1'b1) begin n_fail++;
      $display("FAIL reg_x0_ready: got %0b want 1", b_id_ready); end
    @(negedge clk);
    b_id_we = 0;
    #1;
    n_chk++; if (b_rf_we !== 1'b0) begin n_fail++;
      $display("FAIL reg_x0_we: got %0b want 0", b_rf_we); end
    @(negedge clk);
    b_cop_issue = 1; b_cop_issue_waddr = 13;
    @(negedge clk);
    b_cop_issue = 0;
    b_cop_valid = 1; b_cop_waddr = 13; b_cop_wdata = 32'hC0DE;
    @(negedge clk);
    b_cop_valid = 0;
    #1;
    n_chk++; if ({b_rf_we, b_rf_waddr, b_rf_pending[13]} !== {1'b1, 5'd13, 1'b1})
    begin n_fail++; $display("FAIL reg_cop_wr: got %0b/%0d/p%0b want 1/13/p1",
                             b_rf_we, b_rf_waddr, b_rf_pending[13]); end
    @(negedge clk);
    #1;
    n_chk++; if (b_rf_pending !== 32'h0) begin n_fail++;
      $display("FAIL reg_cop_clr: got %h want 0", b_rf_pending); end
    @(negedge clk);
    b_cop_issue = 1; b_cop_issue_waddr = 11;
    @(negedge clk);
    b_cop_issue_waddr = 12;
    @(negedge clk);
    b_cop_issue = 0;
    #1;
    n_chk++; if ({b_rf_pending, b_cop_out} !== {32'h1800, 3'd2}) begin n_fail++;
      $display("FAIL reg_inflight: got %h/%0d want 1800/2",
               b_rf_pending, b_cop_out); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({b_rf_pending, b_cop_out, b_rf_we} !== 36'h0) begin n_fail++;
      $display("FAIL reg_async_rst: got %h/%0d/%0b want 0",
               b_rf_pending, b_cop_out, b_rf_we); end
    n_chk++; if ({rf_pending, cop_out} !== 35'h0) begin n_fail++;
      $display("FAIL async_rst: got %h/%0d want 0", rf_pending, cop_out); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    zero_inputs();
    test_reset();
    test_lsu_priority();
    test_contention();
    test_issue_fill();
    test_waw_same_cycle();
    test_random();
    test_regout();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
